// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode legality check for the ALU command driver.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OP_SUB = 4'b0001;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response FIFO: head entry is always driven straight from storage registers.
module alu_rsp_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rptr];
  assign valid    = (count != '0);

endmodule

// File: rtl/alu_driver.sv
// Command-side initiator for the registered ALU: issues one operation at a time,
// waits out the ALU latency and returns results in order through a response FIFO.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int CW    = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] last_result;
  logic [CNT_W-1:0] fifo_count;
  logic             legal;
  logic             accept;
  logic             capture;
  logic             push;
  logic [WIDTH:0]   push_data;
  logic [WIDTH:0]   pop_data;

  assign legal = is_legal_op(cmd_op);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && legal) state_nx = WAIT;
      WAIT:    if (cnt == '0)       state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshakes: a transfer happens on any rising edge where valid && ready are
  // both high; valid never depends on ready, and ready may depend on valid-free state only.
  always_comb begin
    cmd_ready = (state == IDLE) && (fifo_count < CNT_W'(DEPTH));
    accept    = cmd_valid && cmd_ready;
    capture   = (state == WAIT) && (cnt == '0);
    push      = capture || (accept && !legal);
    push_data = capture ? {1'b0, alu_result} : {1'b1, {WIDTH{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      last_result <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= ALU_OP_ADD;
    end else begin
      if (accept && legal) begin
        alu_a  <= cmd_chain ? last_result : cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
        cnt    <= CW'(LAT);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) last_result <= alu_result;
    end
  end

  alu_rsp_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_ready),
    .pop_data  (pop_data),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );

  assign rsp_err   = pop_data[WIDTH];
  assign rsp_data  = pop_data[WIDTH-1:0];
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_driver.sv
// Directed closed-loop bench: alu_driver drives a one-cycle registered ALU model.
module tb_alu_driver;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'h0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       cmd_chain = 1'b0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  state_t     dbg_state;

  int compared = 0;
  int mismatched = 0;
  logic [8:0] exp_q[$];

  alu_driver #(.WIDTH(8), .LAT(1), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Registered ALU with latency 1
  always_ff @(posedge clk) begin
    case (alu_op)
      4'h0:    alu_result <= alu_a + alu_b;
      4'h1:    alu_result <= alu_a - alu_b;
      default: alu_result <= 8'h00;
    endcase
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic chain);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    compared++;
    if (!cmd_ready) begin
      mismatched++;
      $display("FAIL send_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pop(output logic [7:0] d, output logic e, output logic ok);
    int n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    ok = rsp_valid; d = rsp_data; e = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    compared++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b data=%h err=%0b busy=%0b required 1 0 00 0 0",
               cmd_ready, rsp_valid, rsp_data, rsp_err, busy);
    end
    compared++;
    if ({alu_a, alu_b, alu_op} !== 20'h0 || dbg_state !== IDLE) begin
      mismatched++;
      $display("FAIL reset_alu: a=%h b=%h op=%h state=%0d required 00 00 0 IDLE",
               alu_a, alu_b, alu_op, dbg_state);
    end
  endtask

  task automatic test_add_timing();
    send(ALU_OP_ADD, 8'h03, 8'h05, 1'b0);
    compared++;
    if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_op} !== {1'b0, 1'b0, 8'h03, 8'h05, 4'h0}
        || dbg_state !== WAIT) begin
      mismatched++;
      $display("FAIL add_edge0: ready=%0b valid=%0b a=%h b=%h op=%h required 0 0 03 05 0",
               cmd_ready, rsp_valid, alu_a, alu_b, alu_op);
    end
    tick();
    compared++;
    if ({cmd_ready, rsp_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL add_edge1: ready=%0b valid=%0b required 0 0", cmd_ready, rsp_valid);
    end
    tick();
    compared++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 1'b0, 8'h08}) begin
      mismatched++;
      $display("FAIL add_edge2: ready=%0b valid=%0b err=%0b data=%h required 1 1 0 08",
               cmd_ready, rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    compared++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL add_drained: valid=%0b busy=%0b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d; logic e, ok;
    send(ALU_OP_SUB, 8'h05, 8'h07, 1'b0);
    pop(d, e, ok);
    compared++;
    if (!ok || d !== 8'hFE || e !== 1'b0) begin
      mismatched++;
      $display("FAIL sub_borrow: ok=%0b data=%h err=%0b required 1 fe 0", ok, d, e);
    end
    send(ALU_OP_ADD, 8'hFF, 8'h01, 1'b0);
    pop(d, e, ok);
    compared++;
    if (!ok || d !== 8'h00 || e !== 1'b0) begin
      mismatched++;
      $display("FAIL add_wrap: ok=%0b data=%h err=%0b required 1 00 0", ok, d, e);
    end
  endtask

  task automatic test_chain();
    logic [7:0] d; logic e, ok;
    send(ALU_OP_ADD, 8'h10, 8'h20, 1'b0);
    send(ALU_OP_SUB, 8'hAA, 8'h08, 1'b1);
    pop(d, e, ok);
    compared++;
    if (!ok || d !== 8'h30 || e !== 1'b0) begin
      mismatched++;
      $display("FAIL chain_first: ok=%0b data=%h err=%0b required 1 30 0", ok, d, e);
    end
    pop(d, e, ok);
    compared++;
    if (!ok || d !== 8'h28 || e !== 1'b0) begin
      mismatched++;
      $display("FAIL chain_second: ok=%0b data=%h err=%0b required 1 28 0", ok, d, e);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] d; logic e, ok;
    send(4'h7, 8'h01, 8'h02, 1'b0);
    compared++;
    if ({rsp_valid, rsp_err, rsp_data, cmd_ready} !== {1'b1, 1'b1, 8'h00, 1'b1}) begin
      mismatched++;
      $display("FAIL illegal_push: valid=%0b err=%0b data=%h ready=%0b required 1 1 00 1",
               rsp_valid, rsp_err, rsp_data, cmd_ready);
    end
    compared++;
    if ({alu_a, alu_b, alu_op} !== {8'h30, 8'h08, 4'h1} || dbg_state !== IDLE) begin
      mismatched++;
      $display("FAIL illegal_alu_hold: a=%h b=%h op=%h required 30 08 1", alu_a, alu_b, alu_op);
    end
    send(4'hF, 8'h11, 8'h22, 1'b0);
    send(ALU_OP_ADD, 8'hAA, 8'h02, 1'b1);
    pop(d, e, ok);
    compared++;
    if (!ok || d !== 8'h00 || e !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_rsp1: ok=%0b data=%h err=%0b required 1 00 1", ok, d, e);
    end
    pop(d, e, ok);
    compared++;
    if (!ok || d !== 8'h00 || e !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_rsp2: ok=%0b data=%h err=%0b required 1 00 1", ok, d, e);
    end
    pop(d, e, ok);
    compared++;
    if (!ok || d !== 8'h2A || e !== 1'b0) begin
      mismatched++;
      $display("FAIL chain_after_illegal: ok=%0b data=%h err=%0b required 1 2a 0", ok, d, e);
    end
  endtask

  task automatic test_full();
    logic [7:0] d; logic e, ok;
    logic [8:0] exp;
    for (int i = 1; i <= 4; i++) begin
      send(ALU_OP_ADD, 8'(i), 8'h01, 1'b0);
      exp_q.push_back({1'b0, 8'(i + 1)});
    end
    tick(); tick();
    compared++;
    if ({cmd_ready, busy, rsp_valid, rsp_data} !== {1'b0, 1'b1, 1'b1, 8'h02}) begin
      mismatched++;
      $display("FAIL full_ready_low: ready=%0b busy=%0b valid=%0b head=%h required 0 1 1 02",
               cmd_ready, busy, rsp_valid, rsp_data);
    end
    cmd_op = ALU_OP_ADD; cmd_a = 8'h40; cmd_b = 8'h01; cmd_chain = 1'b0; cmd_valid = 1'b1;
    tick(); tick(); tick();
    compared++;
    if (cmd_ready !== 1'b0 || alu_a !== 8'h04) begin
      mismatched++;
      $display("FAIL full_held_off: ready=%0b a=%h required 0 04", cmd_ready, alu_a);
    end
    pop(d, e, ok);
    exp = exp_q.pop_front();
    compared++;
    if (!ok || {e, d} !== exp) begin
      mismatched++;
      $display("FAIL full_pop0: ok=%0b got=%h required %h", ok, {e, d}, exp);
    end
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL full_ready_after_pop: ready=%0b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back({1'b0, 8'h41});
    compared++;
    if (alu_a !== 8'h40 || cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_fifth_accept: a=%h ready=%0b required 40 0", alu_a, cmd_ready);
    end
    while (exp_q.size() != 0) begin
      pop(d, e, ok);
      exp = exp_q.pop_front();
      compared++;
      if (!ok || {e, d} !== exp) begin
        mismatched++;
        $display("FAIL full_drain: ok=%0b got=%h required %h", ok, {e, d}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] d; logic e, ok;
    send(4'h9, 8'h00, 8'h00, 1'b0);
    send(ALU_OP_ADD, 8'h11, 8'h22, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    compared++;
    if ({rsp_valid, busy, cmd_ready, alu_a, alu_b, alu_op} !== {1'b0, 1'b0, 1'b1, 20'h0}) begin
      mismatched++;
      $display("FAIL midwait_reset: valid=%0b busy=%0b ready=%0b a=%h b=%h op=%h required 0 0 1 00 00 0",
               rsp_valid, busy, cmd_ready, alu_a, alu_b, alu_op);
    end
    tick(); tick(); tick(); tick();
    compared++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midwait_no_late: valid=%0b busy=%0b required 0 0", rsp_valid, busy);
    end
    send(ALU_OP_ADD, 8'hEE, 8'h05, 1'b1);
    pop(d, e, ok);
    compared++;
    if (!ok || d !== 8'h05 || e !== 1'b0) begin
      mismatched++;
      $display("FAIL chain_after_reset: ok=%0b data=%h err=%0b required 1 05 0", ok, d, e);
    end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_wrap();
    test_chain();
    test_illegal();
    test_full();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
